// File: rtl/mem_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_pkg
//   Shared definitions for the dual-core data-memory request arbiter:
//   default widths, region-select encodings, the registered load-source
//   encoding and the two-way round-robin pick function.
// -----------------------------------------------------------------------------
package mem_req_arbiter_pkg;

  localparam int TAM_DEF  = 16;  // data and address width
  localparam int LMEM_DEF = 8;   // memory index width; addr[Lmem] is the region bit

  // Value of addr[Lmem]
  localparam logic REGION_PRIV   = 1'b0;
  localparam logic REGION_SHARED = 1'b1;

  // Where a pending load's data comes from on the response cycle
  typedef enum logic {
    RD_SRC_PRIV   = 1'b0,
    RD_SRC_SHARED = 1'b1
  } rd_src_e;

  // Two-way round-robin pick. On a conflict the core that did not win last
  // time takes the port; a lone request always wins. Result is one-hot or zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_if
//   Bundles every non-clock signal of the arbiter: the two core request /
//   response channels, the two private-bank ports and the shared-bank port.
//   slave  : the arbiter's view (requests and RAM read data in, the rest out)
//   master : the environment's view (cores plus RAMs)
// -----------------------------------------------------------------------------
interface mem_req_arbiter_if
  import mem_req_arbiter_pkg::*;
#(
  parameter int TAM  = TAM_DEF,
  parameter int Lmem = LMEM_DEF
);

  // Core 0 request / response
  logic            req0_valid;
  logic            req0_we;
  logic [TAM-1:0]  req0_addr;
  logic [TAM-1:0]  req0_wdata;
  logic            req0_ready;
  logic            rsp0_valid;
  logic [TAM-1:0]  rsp0_rdata;

  // Core 1 request / response
  logic            req1_valid;
  logic            req1_we;
  logic [TAM-1:0]  req1_addr;
  logic [TAM-1:0]  req1_wdata;
  logic            req1_ready;
  logic            rsp1_valid;
  logic [TAM-1:0]  rsp1_rdata;

  // Private bank ports
  logic            priv0_en;
  logic            priv0_we;
  logic [Lmem-1:0] priv0_addr;
  logic [TAM-1:0]  priv0_wdata;
  logic [TAM-1:0]  priv0_rdata;
  logic            priv1_en;
  logic            priv1_we;
  logic [Lmem-1:0] priv1_addr;
  logic [TAM-1:0]  priv1_wdata;
  logic [TAM-1:0]  priv1_rdata;

  // Shared bank port
  logic            sh_en;
  logic            sh_we;
  logic [Lmem-1:0] sh_addr;
  logic [TAM-1:0]  sh_wdata;
  logic [TAM-1:0]  sh_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output priv0_en, priv0_we, priv0_addr, priv0_wdata,
    output priv1_en, priv1_we, priv1_addr, priv1_wdata,
    input  priv0_rdata, priv1_rdata,
    output sh_en, sh_we, sh_addr, sh_wdata,
    input  sh_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  priv0_en, priv0_we, priv0_addr, priv0_wdata,
    input  priv1_en, priv1_we, priv1_addr, priv1_wdata,
    output priv0_rdata, priv1_rdata,
    input  sh_en, sh_we, sh_addr, sh_wdata,
    output sh_rdata
  );

endinterface

// File: rtl/mem_req_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter for the shared-bank port.
//   clk, rst       : clock, synchronous active-high reset
//   req_i[1:0]     : shared-bank requests from core 0 / core 1
//   advance_i      : a grant issued this cycle is taken (updates last_grant)
//   gnt_o[1:0]     : combinational grant, one-hot or zero
//   last_grant_o   : core that won the most recent shared grant (resets to 1)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_req_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       last_grant_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt_o        = rr_pick(req_i, last_grant_q);
    last_grant_d = last_grant_q;
    // Only a cycle that actually grants moves the pointer
    if (advance_i && (gnt_o != 2'b00)) begin
      last_grant_d = gnt_o[1];
    end
  end

  // Reset to core 1 so core 0 wins the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Sits in front of the dual-core data memory. Each core issues at most one
//   load/store per cycle; addr[Lmem] picks the core-private bank (0) or the
//   single-ported shared bank (1). Private requests are accepted at once;
//   shared requests are serialised round-robin. Load data returns one cycle
//   after acceptance with rspN_valid.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_req_arbiter_if.slave -- core request/response channels,
//              private bank 0/1 ports, shared bank port
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int TAM  = TAM_DEF,
  parameter int Lmem = LMEM_DEF
)(
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.slave  bus
);

  logic [1:0] sh_req;
  logic [1:0] gnt;
  logic       last_grant;
  logic       is_sh0, is_sh1;
  logic       rdy0, rdy1;
  logic       sel1;

  logic [1:0] rd_pend_q, rd_pend_d;
  rd_src_e    rd_src0_q, rd_src0_d;
  rd_src_e    rd_src1_q, rd_src1_d;

  // Upper address bits are deliberately ignored
  logic unused_hi_bits;
  assign unused_hi_bits = ^{bus.req0_addr[TAM-1:Lmem+1], bus.req1_addr[TAM-1:Lmem+1]};

  assign is_sh0 = (bus.req0_addr[Lmem] == REGION_SHARED);
  assign is_sh1 = (bus.req1_addr[Lmem] == REGION_SHARED);

  // Nothing competes while reset is held, so nothing is granted either
  assign sh_req = {~rst & bus.req1_valid & is_sh1,
                   ~rst & bus.req0_valid & is_sh0};

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (sh_req),
    .advance_i    (~rst),
    .gnt_o        (gnt),
    .last_grant_o (last_grant)
  );

  // ---- request side: region decode, ready, bank strobes ----
  always_comb begin
    rdy0 = ~rst & bus.req0_valid & (~is_sh0 | gnt[0]);
    rdy1 = ~rst & bus.req1_valid & (~is_sh1 | gnt[1]);
    sel1 = gnt[1];

    bus.req0_ready  = rdy0;
    bus.req1_ready  = rdy1;

    bus.priv0_en    = ~rst & bus.req0_valid & ~is_sh0;
    bus.priv0_we    = ~rst & bus.req0_valid & ~is_sh0 & bus.req0_we;
    bus.priv0_addr  = bus.req0_addr[Lmem-1:0];
    bus.priv0_wdata = bus.req0_wdata;

    bus.priv1_en    = ~rst & bus.req1_valid & ~is_sh1;
    bus.priv1_we    = ~rst & bus.req1_valid & ~is_sh1 & bus.req1_we;
    bus.priv1_addr  = bus.req1_addr[Lmem-1:0];
    bus.priv1_wdata = bus.req1_wdata;

    // Shared port carries whichever core holds the grant
    bus.sh_en    = (gnt != 2'b00);
    bus.sh_we    = (gnt != 2'b00) & (sel1 ? bus.req1_we : bus.req0_we);
    bus.sh_addr  = sel1 ? bus.req1_addr[Lmem-1:0] : bus.req0_addr[Lmem-1:0];
    bus.sh_wdata = sel1 ? bus.req1_wdata : bus.req0_wdata;

    // A load accepted now owes a response next cycle from the bank it used
    rd_pend_d = {rdy1 & ~bus.req1_we, rdy0 & ~bus.req0_we};
    rd_src0_d = is_sh0 ? RD_SRC_SHARED : RD_SRC_PRIV;
    rd_src1_d = is_sh1 ? RD_SRC_SHARED : RD_SRC_PRIV;
  end

  // ---- response pipeline register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
    rd_src0_q <= rd_src0_d;
    rd_src1_q <= rd_src1_d;
  end

  // ---- response side: data mux from the registered source ----
  always_comb begin
    bus.rsp0_valid = ~rst & rd_pend_q[0];
    bus.rsp1_valid = ~rst & rd_pend_q[1];
    bus.rsp0_rdata = '0;
    bus.rsp1_rdata = '0;
    if (bus.rsp0_valid) begin
      bus.rsp0_rdata = (rd_src0_q == RD_SRC_SHARED) ? bus.sh_rdata : bus.priv0_rdata;
    end
    if (bus.rsp1_valid) begin
      bus.rsp1_rdata = (rd_src1_q == RD_SRC_SHARED) ? bus.sh_rdata : bus.priv1_rdata;
    end
  end

  // Exposed for waveform inspection only
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int TAM  = 16;
  localparam int LMEM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.TAM(TAM), .Lmem(LMEM)) bus ();

  mem_req_arbiter #(.TAM(TAM), .Lmem(LMEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---- RAM models: 1-cycle synchronous read ----
  logic [TAM-1:0] ram_p0 [256];
  logic [TAM-1:0] ram_p1 [256];
  logic [TAM-1:0] ram_sh [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.priv0_en) begin
      if (bus.priv0_we) ram_p0[bus.priv0_addr] <= bus.priv0_wdata;
      else              bus.priv0_rdata <= ram_p0[bus.priv0_addr];
    end
    if (bus.priv1_en) begin
      if (bus.priv1_we) ram_p1[bus.priv1_addr] <= bus.priv1_wdata;
      else              bus.priv1_rdata <= ram_p1[bus.priv1_addr];
    end
    if (bus.sh_en) begin
      if (bus.sh_we) ram_sh[bus.sh_addr] <= bus.sh_wdata;
      else           bus.sh_rdata <= ram_sh[bus.sh_addr];
    end
  end

  // ---- reference model + scoreboard ----
  typedef struct packed {
    int             cyc;
    logic [TAM-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_item;

  logic [TAM-1:0]  ref_p0 [256];
  logic [TAM-1:0]  ref_p1 [256];
  logic [TAM-1:0]  ref_sh [256];
  logic            m_lg;
  logic            m_s0, m_s1, m_g0, m_g1, m_r0, m_r1;
  logic [LMEM-1:0] m_i0, m_i1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rdy0",  bus.req0_ready, 0);
      chk("rst_rdy1",  bus.req1_ready, 0);
      chk("rst_p0en",  bus.priv0_en, 0);
      chk("rst_p1en",  bus.priv1_en, 0);
      chk("rst_shen",  bus.sh_en, 0);
      chk("rst_shwe",  bus.sh_we, 0);
      chk("rst_rsp0v", bus.rsp0_valid, 0);
      chk("rst_rsp1v", bus.rsp1_valid, 0);
      chk("rst_rsp0d", bus.rsp0_rdata, 0);
      q0.delete();
      q1.delete();
      m_lg = 1'b1;
    end else begin
      // responses due this cycle
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e_item = q0.pop_front();
        chk("rsp0_valid", bus.rsp0_valid, 1);
        chk("rsp0_rdata", bus.rsp0_rdata, e_item.data);
      end else if (bus.rsp0_valid) begin
        chk("rsp0_spurious", bus.rsp0_valid, 0);
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e_item = q1.pop_front();
        chk("rsp1_valid", bus.rsp1_valid, 1);
        chk("rsp1_rdata", bus.rsp1_rdata, e_item.data);
      end else if (bus.rsp1_valid) begin
        chk("rsp1_spurious", bus.rsp1_valid, 0);
      end

      // expected acceptance this cycle
      m_s0 = bus.req0_valid & bus.req0_addr[LMEM];
      m_s1 = bus.req1_valid & bus.req1_addr[LMEM];
      if (m_s0 && m_s1) begin
        m_g0 = m_lg;
        m_g1 = ~m_lg;
      end else begin
        m_g0 = m_s0;
        m_g1 = m_s1;
      end
      m_r0 = bus.req0_valid & (~bus.req0_addr[LMEM] | m_g0);
      m_r1 = bus.req1_valid & (~bus.req1_addr[LMEM] | m_g1);
      chk("rdy0",  bus.req0_ready, m_r0);
      chk("rdy1",  bus.req1_ready, m_r1);
      chk("p0_en", bus.priv0_en, bus.req0_valid & ~bus.req0_addr[LMEM]);
      chk("p1_en", bus.priv1_en, bus.req1_valid & ~bus.req1_addr[LMEM]);
      chk("sh_en", bus.sh_en, m_g0 | m_g1);
      chk("sh_we", bus.sh_we, (m_g0 & bus.req0_we) | (m_g1 & bus.req1_we));
      if (m_g0 | m_g1) m_lg = m_g1;

      m_i0 = bus.req0_addr[LMEM-1:0];
      m_i1 = bus.req1_addr[LMEM-1:0];
      // loads read the pre-cycle contents; each bank serves one access per cycle
      if (m_r0 && !bus.req0_we)
        q0.push_back('{cyc: cyc + 1, data: (m_s0 ? ref_sh[m_i0] : ref_p0[m_i0])});
      if (m_r1 && !bus.req1_we)
        q1.push_back('{cyc: cyc + 1, data: (m_s1 ? ref_sh[m_i1] : ref_p1[m_i1])});
      if (m_r0 && bus.req0_we) begin
        if (m_s0) ref_sh[m_i0] = bus.req0_wdata;
        else      ref_p0[m_i0] = bus.req0_wdata;
      end
      if (m_r1 && bus.req1_we) begin
        if (m_s1) ref_sh[m_i1] = bus.req1_wdata;
        else      ref_p1[m_i1] = bus.req1_wdata;
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 16'h0, 16'h0);
    drv1(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    m_lg = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ram_p0[i] = '0; ram_p1[i] = '0; ram_sh[i] = '0;
      ref_p0[i] = '0; ref_p1[i] = '0; ref_sh[i] = '0;
    end
    bus.priv0_rdata = '0;
    bus.priv1_rdata = '0;
    bus.sh_rdata    = '0;

    // 1: reset held 3 cycles with both cores requesting, then first conflict
    drv0(1'b1, 1'b0, 16'h0100, 16'h0);
    drv1(1'b1, 1'b0, 16'h0101, 16'h0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_first_gnt0", bus.req0_ready, 1);
    chk("t1_first_gnt1", bus.req1_ready, 0);
    tick();
    drv0(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t1_held_gnt1", bus.req1_ready, 1);
    tick();
    idle();
    tick();

    // 2: private store then load
    drv0(1'b1, 1'b1, 16'h0005, 16'h1234);
    @(negedge clk);
    chk("t2_st_rdy", bus.req0_ready, 1);
    chk("t2_st_we",  bus.priv0_we, 1);
    tick();
    drv0(1'b1, 1'b0, 16'h0005, 16'h0);
    tick();
    idle();
    @(negedge clk);
    chk("t2_rsp_v", bus.rsp0_valid, 1);
    chk("t2_rsp_d", bus.rsp0_rdata, 16'h1234);
    tick();

    // 3: same-address shared stores, loser lands last
    drv0(1'b1, 1'b1, 16'h010A, 16'hAAAA);
    drv1(1'b1, 1'b1, 16'h010A, 16'h5555);
    @(negedge clk);
    chk("t3_c0_gnt0", bus.req0_ready, 1);
    chk("t3_c0_gnt1", bus.req1_ready, 0);
    tick();
    drv0(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t3_c1_gnt1", bus.req1_ready, 1);
    tick();
    idle();
    tick();
    drv1(1'b1, 1'b0, 16'h010A, 16'h0);
    tick();
    idle();
    @(negedge clk);
    chk("t3_rd_v", bus.rsp1_valid, 1);
    chk("t3_rd_d", bus.rsp1_rdata, 16'h5555);
    tick();

    // preload shared words for test 4 (core1 last so core0 wins next)
    drv0(1'b1, 1'b1, 16'h0120, 16'h0C0C);
    tick();
    idle();
    drv1(1'b1, 1'b1, 16'h0130, 16'h1D1D);
    tick();
    idle();
    tick();

    // 4: held shared loads from both cores, grants alternate
    drv0(1'b1, 1'b0, 16'h0120, 16'h0);
    drv1(1'b1, 1'b0, 16'h0130, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_gnt0", bus.req0_ready, (k % 2 == 0));
      chk("t4_gnt1", bus.req1_ready, (k % 2 == 1));
      if (k > 0) begin
        chk("t4_rsp0v", bus.rsp0_valid, (k % 2 == 1));
        chk("t4_rsp1v", bus.rsp1_valid, (k % 2 == 0));
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("t4_last_rsp1v", bus.rsp1_valid, 1);
    chk("t4_last_rsp1d", bus.rsp1_rdata, 16'h1D1D);
    tick();

    // 5: private load and shared store together
    drv0(1'b1, 1'b0, 16'h0005, 16'h0);
    drv1(1'b1, 1'b1, 16'h0140, 16'h7777);
    @(negedge clk);
    chk("t5_rdy0",   bus.req0_ready, 1);
    chk("t5_rdy1",   bus.req1_ready, 1);
    chk("t5_p0en",   bus.priv0_en, 1);
    chk("t5_shwe",   bus.sh_we, 1);
    chk("t5_shaddr", bus.sh_addr, 8'h40);
    tick();
    idle();
    @(negedge clk);
    chk("t5_rsp0d", bus.rsp0_rdata, 16'h1234);
    tick();

    // 6: reset right after an accepted shared load drops the response
    drv0(1'b1, 1'b0, 16'h0120, 16'h0);
    @(negedge clk);
    chk("t6_rdy0", bus.req0_ready, 1);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rsp_in_rst", bus.rsp0_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_after_v", bus.rsp0_valid, 0);
    chk("t6_rsp_after_d", bus.rsp0_rdata, 0);
    repeat (3) tick();

    @(negedge clk);
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
